parity_checker_pipe: RTL
========================

# parity_checker_pipe

Registered, multi-lane parity checker between a FIFO pop port and its receiver. Every accepted word is split into LANES groups of DATA_WIDTH payload bits plus one parity bit, each group is checked against the configured parity sense, and the parity bits are stripped off. The block then either forwards the word with per-lane error flags or discards it, depending on DROP_MODE. A one-entry output register gives one cycle of latency at full throughput, and the block keeps a sticky error flag and a saturating error counter.

## Interface
- EVEN_ODD, 0, parity sense: 0 = even (XOR of the 9-bit group == 0), 1 = odd (XOR == 1)
- SELECT_PARITY_BIT, 0, parity bit position within each group: 1 = MSB (bit DATA_WIDTH), 0 = LSB (bit 0)
- DATA_WIDTH, 8, payload bits per lane
- LANES, 1, number of parity-protected groups per word (≥1)
- DROP_MODE, 0, 0 = forward bad words with flags; 1 = consume and discard bad words
- ERR_CNT_WIDTH, 8, error counter width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- data_in  in  LANES*(DATA_WIDTH+1)  FIFO word; lane i = data_in[i*(DATA_WIDTH+1) +: DATA_WIDTH+1]
- pop_valid_fifo  in  1  FIFO has a word
- pop_grant_fifo  out  1  block accepts the word this cycle
- pop_valid_receiver  out  1  output register holds a word
- pop_grant_receiver  in  1  receiver takes the word this cycle
- data_out  out  LANES*DATA_WIDTH  stripped payload; lane i = data_out[i*DATA_WIDTH +: DATA_WIDTH]
- lane_err_out  out  LANES  per-lane parity failure of the held word
- err_clear  in  1  synchronous clear of err_sticky and err_count
- err_sticky  out  1  set by any accepted bad word
- err_count  out  ERR_CNT_WIDTH  saturating count of accepted bad words

## Operation
- Input transfer (IT): pop_valid_fifo && pop_grant_fifo. Output transfer (OT): pop_valid_receiver && pop_grant_receiver.
- pop_grant_fifo = rst_n && (!pop_valid_receiver || pop_grant_receiver). This is combinational from the receiver grant, with no bubble.
- Lane check: lane i is bad when the XOR of all DATA_WIDTH+1 bits != EVEN_ODD. A word is bad when any lane is bad.
- Payload extraction:
  - SELECT_PARITY_BIT=1: the lower DATA_WIDTH bits of the group.
  - SELECT_PARITY_BIT=0: the upper DATA_WIDTH bits of the group.
- Output register, two states:
  - EMPTY (pop_valid_receiver=0).
  - FULL (pop_valid_receiver=1).
- Output register update each cycle:
  - On IT with a good word, or with a bad word and DROP_MODE=0: load data_out and lane_err_out, and go to FULL.
  - On IT with a bad word and DROP_MODE=1: do not load. The state goes to EMPTY if an OT occurs this cycle; otherwise it is unchanged.
  - With no load: an OT goes to EMPTY; otherwise the state holds.
- Stability: while FULL and not granted, data_out and lane_err_out hold stable.
- Error events: each IT of a bad word sets err_sticky and increments err_count by 1. The count is per word, not per lane, and saturates at 2^ERR_CNT_WIDTH-1.
- err_clear has priority over a same-cycle error event: the result is sticky=0 and count=0.

## Timing
- Reset values (asynchronous on rst_n low): pop_valid_receiver=0, data_out=0, lane_err_out=0, err_sticky=0, err_count=0. pop_grant_fifo=0 while rst_n is low.
- Latency: a word accepted at edge N is on data_out with pop_valid_receiver=1 after edge N.
- Throughput: one word per cycle with a continuous pop_grant_receiver.
- Drop latency: a dropped word updates err_count and err_sticky after the accepting edge and never appears at the output.
- Reset mid-transfer: a held word is lost. After release, pop_grant_fifo=1 in the first cycle.
- Error outputs are registered and update on the edge after the event.

## Configuration
- PARITY_ERR_CNT_EN defined: err_count is implemented as specified.
- PARITY_ERR_CNT_EN undefined: no counter flops exist and err_count is tied to 0. err_sticky, dropping and flagging are unaffected.

## Test plan
Common setup: DATA_WIDTH=8, LANES=2, EVEN_ODD=0, SELECT_PARITY_BIT=0, PARITY_ERR_CNT_EN defined. Reference lane values: good lane 9'h0AA (payload 0x55, parity bit 0); bad lane 9'h0AB.

1. Reset then stream: rst_n low → all outputs 0 and pop_grant_fifo=0. Release, then drive data_in={9'h0AA,9'h0AA} valid with the receiver granting → data_out=16'h5555, lane_err_out=0, one cycle latency, one word per cycle.
2. Flag mode (DROP_MODE=0): data_in={9'h0AA,9'h0AB} → word forwarded with lane_err_out=2'b01, err_sticky=1, err_count=1.
3. Drop mode (DROP_MODE=1): good, bad, good sequence → receiver sees exactly the two good words, err_count=1, with no stall toward the FIFO.
4. Backpressure: hold pop_grant_receiver=0 while FULL → pop_grant_fifo=0 and data_out stable for 5 cycles. Release → the held word transfers and the next word loads in the same cycle.
5. Counter limits, with ERR_CNT_WIDTH=2: five bad words → err_count saturates at 3. err_clear asserted in the same cycle as a sixth bad word → count=0 and sticky=0.
6. Reset mid-operation: assert rst_n while FULL and stalled → pop_valid_receiver=0 immediately and the held word is never delivered. Repeat with PARITY_ERR_CNT_EN undefined → err_count stays 0 throughout.

Source files
------------

// File: rtl/parity_checker_pipe.sv
`default_nettype none
// ============================================================================
// Module      : parity_checker_pipe
// Description : Multi-lane parity checker with parity stripping, one-entry
//               output register, sticky error flag and saturating error
//               counter. Define PARITY_ERR_CNT_EN to build the error counter.
// Revision    : 1.0 - initial release
// ============================================================================
module parity_checker_pipe #(
    parameter int EVEN_ODD          = 0,
    parameter int SELECT_PARITY_BIT = 0,
    parameter int DATA_WIDTH        = 8,
    parameter int LANES             = 1,
    parameter int DROP_MODE         = 0,
    parameter int ERR_CNT_WIDTH     = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [LANES*(DATA_WIDTH+1)-1:0] data_in,
    input  logic                          pop_valid_fifo,
    output logic                          pop_grant_fifo,
    output logic                          pop_valid_receiver,
    input  logic                          pop_grant_receiver,
    output logic [LANES*DATA_WIDTH-1:0]   data_out,
    output logic [LANES-1:0]              lane_err_out,
    input  logic                          err_clear,
    output logic                          err_sticky,
    output logic [ERR_CNT_WIDTH-1:0]      err_count
);

    localparam int   c_GROUP_W = DATA_WIDTH + 1;
    localparam logic c_SENSE   = 1'(EVEN_ODD);
    localparam logic c_DROP    = (DROP_MODE != 0);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [LANES*DATA_WIDTH-1:0]   r_data;
    logic [LANES-1:0]              r_lane_err;
    logic                          r_err_sticky;
    logic [LANES-1:0]              w_lane_bad;
    logic [LANES*DATA_WIDTH-1:0]   w_payload;
    logic                          w_word_bad;
    logic                          w_in_xfer;
    logic                          w_out_xfer;
    logic                          w_load;
    logic                          w_err_event;

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            logic [c_GROUP_W-1:0] w_group;
            assign w_group       = data_in[i*c_GROUP_W +: c_GROUP_W];
            assign w_lane_bad[i] = (^w_group) != c_SENSE;
            if (SELECT_PARITY_BIT != 0) begin : g_par_msb
                assign w_payload[i*DATA_WIDTH +: DATA_WIDTH] = w_group[DATA_WIDTH-1:0];
            end else begin : g_par_lsb
                assign w_payload[i*DATA_WIDTH +: DATA_WIDTH] = w_group[DATA_WIDTH:1];
            end
        end
    endgenerate

    assign w_word_bad  = |w_lane_bad;
    assign pop_valid_receiver = (r_state == ST_FULL);
    // Grant is combinational from the receiver so a full register never bubbles.
    assign pop_grant_fifo = rst_n && (!pop_valid_receiver || pop_grant_receiver);
    assign w_in_xfer   = pop_valid_fifo && pop_grant_fifo;
    assign w_out_xfer  = pop_valid_receiver && pop_grant_receiver;
    assign w_load      = w_in_xfer && (!w_word_bad || !c_DROP);
    assign w_err_event = w_in_xfer && w_word_bad;

    always_comb begin
        w_state_nxt = r_state;
        if (w_load) begin
            w_state_nxt = ST_FULL;
        end else if (w_out_xfer) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_EMPTY;
            r_data     <= '0;
            r_lane_err <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_data     <= w_payload;
                r_lane_err <= w_lane_bad;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_sticky <= 1'b0;
        end else if (err_clear) begin
            r_err_sticky <= 1'b0;
        end else if (w_err_event) begin
            r_err_sticky <= 1'b1;
        end
    end

`ifdef PARITY_ERR_CNT_EN
    logic [ERR_CNT_WIDTH-1:0] r_err_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if (err_clear) begin
            r_err_count <= '0;
        end else if (w_err_event && (r_err_count != {ERR_CNT_WIDTH{1'b1}})) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = '0;
`endif

    assign data_out     = r_data;
    assign lane_err_out = r_lane_err;
    assign err_sticky   = r_err_sticky;

endmodule
`default_nettype wire
